// File: rtl/cbcmac_engine.sv
// CBC-MAC engine: chains message blocks through an external block cipher over valid/accept
// handshakes and emits one (optionally truncated) MAC per message. The IV is fixed at zero.
module cbcmac_engine #(
    parameter int unsigned BLOCK_W = 64,
    parameter int unsigned KEY_W   = 64,
    parameter int unsigned MAC_W   = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,
    // message input
    input  logic               start_i,
    input  logic               last_i,
    input  logic [KEY_W-1:0]   key_i,
    input  logic [BLOCK_W-1:0] data_i,
    input  logic               valid_i,
    output logic               accept_o,
    // MAC output
    output logic [MAC_W-1:0]   data_o,
    output logic               valid_o,
    input  logic               accept_i,
    output logic               error_o,
    // cipher request
    output logic [KEY_W-1:0]   cipher_key_o,
    output logic [BLOCK_W-1:0] cipher_data_o,
    output logic               cipher_valid_o,
    input  logic               cipher_accept_i,
    // cipher response
    input  logic [BLOCK_W-1:0] cipher_data_i,
    input  logic               cipher_valid_i,
    output logic               cipher_accept_o
);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWait,
        StOut
    } state_e;

    state_e             state_q;
    logic [BLOCK_W-1:0] chain_q;
    logic [BLOCK_W-1:0] req_q;
    logic [KEY_W-1:0]   key_q;
    logic               open_q;
    logic               last_q;
    logic               accept_q;
    logic               valid_q;
    logic               error_q;
    logic               cvalid_q;
    logic               caccept_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            chain_q   <= '0;
            req_q     <= '0;
            key_q     <= '0;
            open_q    <= 1'b0;
            last_q    <= 1'b0;
            accept_q  <= 1'b1;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            cvalid_q  <= 1'b0;
            caccept_q <= 1'b0;
        end else begin
            error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (valid_i && accept_q) begin
                        if (start_i) begin
                            // A new start abandons any open message; zero IV means no XOR.
                            key_q    <= key_i;
                            req_q    <= data_i;
                            last_q   <= last_i;
                            accept_q <= 1'b0;
                            cvalid_q <= 1'b1;
                            state_q  <= StSend;
                        end else if (open_q) begin
                            req_q    <= data_i ^ chain_q;
                            last_q   <= last_i;
                            accept_q <= 1'b0;
                            cvalid_q <= 1'b1;
                            state_q  <= StSend;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                StSend: begin
                    if (cipher_accept_i) begin
                        cvalid_q  <= 1'b0;
                        caccept_q <= 1'b1;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (cipher_valid_i) begin
                        chain_q   <= cipher_data_i;
                        caccept_q <= 1'b0;
                        if (last_q) begin
                            open_q  <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= StOut;
                        end else begin
                            open_q   <= 1'b1;
                            accept_q <= 1'b1;
                            state_q  <= StIdle;
                        end
                    end
                end
                StOut: begin
                    if (accept_i) begin
                        chain_q  <= '0;
                        valid_q  <= 1'b0;
                        accept_q <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
            endcase
        end
    end

    // MAC is the leftmost (most-significant) MAC_W bits of the chain value.
    assign data_o          = chain_q[BLOCK_W-1 -: MAC_W];
    assign valid_o         = valid_q;
    assign accept_o        = accept_q;
    assign error_o         = error_q;
    assign cipher_key_o    = key_q;
    assign cipher_data_o   = req_q;
    assign cipher_valid_o  = cvalid_q;
    assign cipher_accept_o = caccept_q;

endmodule

// File: tb/tb_cbcmac_engine.sv
// Bench for cbcmac_engine: a stand-in cipher core, a MAC sink, directed vectors and randomized
// messages checked against a CBC-MAC reference model; a MAC_W=32 instance runs in lockstep.
module tb_cbcmac_engine;

    localparam logic [63:0] KDES  = 64'h133457799BBCDFF1;
    localparam logic [63:0] PDES  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CDES  = 64'h85E813540F0AB405;
    localparam logic [63:0] P2DES = 64'h84CB563386A179EA;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        start_i, last_i, valid_i, accept_i;
    logic [63:0] key_i, data_i;
    logic        accept_o, valid_o, error_o;
    logic [63:0] data_o;
    logic [63:0] cipher_key_o, cipher_data_o, cipher_data_i;
    logic        cipher_valid_o, cipher_accept_i, cipher_valid_i, cipher_accept_o;
    logic        accept_o2, valid_o2, error_o2, cipher_valid_o2, cipher_accept_o2;
    logic [31:0] data_o2;
    logic [63:0] cipher_key_o2, cipher_data_o2;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cbcmac_engine #(.BLOCK_W(64), .KEY_W(64), .MAC_W(64)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .last_i(last_i), .key_i(key_i),
        .data_i(data_i), .valid_i(valid_i), .accept_o(accept_o), .data_o(data_o),
        .valid_o(valid_o), .accept_i(accept_i), .error_o(error_o),
        .cipher_key_o(cipher_key_o), .cipher_data_o(cipher_data_o),
        .cipher_valid_o(cipher_valid_o), .cipher_accept_i(cipher_accept_i),
        .cipher_data_i(cipher_data_i), .cipher_valid_i(cipher_valid_i),
        .cipher_accept_o(cipher_accept_o)
    );

    // Same inputs as dut, so its handshakes track dut cycle for cycle.
    cbcmac_engine #(.BLOCK_W(64), .KEY_W(64), .MAC_W(32)) dut32 (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .last_i(last_i), .key_i(key_i),
        .data_i(data_i), .valid_i(valid_i), .accept_o(accept_o2), .data_o(data_o2),
        .valid_o(valid_o2), .accept_i(accept_i), .error_o(error_o2),
        .cipher_key_o(cipher_key_o2), .cipher_data_o(cipher_data_o2),
        .cipher_valid_o(cipher_valid_o2), .cipher_accept_i(cipher_accept_i),
        .cipher_data_i(cipher_data_i), .cipher_valid_i(cipher_valid_i),
        .cipher_accept_o(cipher_accept_o2)
    );

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Stand-in cipher: reproduces the DES known-answer pair, otherwise a keyed mixing function.
    function automatic logic [63:0] toy(input logic [63:0] k, input logic [63:0] x);
        logic [63:0] y;
        if (k == KDES && x == PDES) return CDES;
        y = x ^ k;
        for (int r = 0; r < 4; r++) y = {y[40:0], y[63:41]} ^ (y * 64'h9E3779B97F4A7C15) ^ k;
        return y;
    endfunction

    // CBC-MAC with zero IV.
    function automatic logic [63:0] ref_mac(input logic [63:0] k, input logic [63:0] b[4],
                                            input int n);
        logic [63:0] c;
        c = '0;
        for (int i = 0; i < n; i++) c = toy(k, c ^ b[i]);
        return c;
    endfunction

    // ---------------- cipher core model ----------------
    logic [63:0] req_key_log[$];
    logic [63:0] req_data_log[$];
    int          cacc_hold = 0;
    int          res_cyc = 0;

    initial begin : cipher_stub
        bit          busy, req_x, res_x, rst_seen;
        int          lat;
        logic [63:0] res, cap_k, cap_d;
        busy = 0; req_x = 0; res_x = 0; rst_seen = 1; lat = 0;
        res = '0; cap_k = '0; cap_d = '0;
        cipher_accept_i = 1'b0; cipher_valid_i = 1'b0; cipher_data_i = '0;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                busy = 0; cipher_valid_i = 1'b0; cipher_accept_i = 1'b0;
            end else begin
                if (res_x) begin
                    busy = 0; cipher_valid_i = 1'b0;
                end
                if (req_x) begin
                    req_key_log.push_back(cap_k);
                    req_data_log.push_back(cap_d);
                    busy = 1;
                    lat = $urandom_range(0, 3);
                    res = toy(cap_k, cap_d);
                end
                if (busy) cipher_accept_i = 1'b0;
                else if (cacc_hold > 0 && cipher_valid_o) begin
                    cipher_accept_i = 1'b0;
                    cacc_hold--;
                end else cipher_accept_i = ($urandom_range(0, 2) != 0);
                if (busy && !cipher_valid_i) begin
                    if (lat == 0) begin
                        cipher_valid_i = 1'b1; cipher_data_i = res;
                    end else lat--;
                end
            end
            #1;
            rst_seen = reset_i;
            req_x = !reset_i && cipher_valid_o && cipher_accept_i;
            res_x = !reset_i && cipher_valid_i && cipher_accept_o;
            cap_k = cipher_key_o;
            cap_d = cipher_data_o;
            if (res_x) res_cyc = cyc + 1;
        end
    end

    // ---------------- MAC sink / monitor ----------------
    logic [63:0] mac_q[$];
    logic [31:0] mac32_q[$];
    int          err_cnt = 0;
    int          rise_cyc = 0;
    int          sink_hold = 0;

    initial begin : sink
        bit vprev;
        bit same;
        vprev = 0;
        accept_i = 1'b0;
        forever begin
            @(negedge clk);
            if (sink_hold > 0 && valid_o) begin
                accept_i = 1'b0;
                sink_hold--;
            end else accept_i = ($urandom_range(0, 2) != 0);
            #1;
            if (!reset_i) begin
                if (valid_o && accept_i) begin
                    mac_q.push_back(data_o);
                    mac32_q.push_back(data_o2);
                end
                if (error_o) err_cnt++;
                if (valid_o && !vprev) rise_cyc = cyc;
            end
            vprev = valid_o;
            same = (accept_o2 == accept_o) && (valid_o2 == valid_o) && (error_o2 == error_o) &&
                   (cipher_valid_o2 == cipher_valid_o) && (cipher_accept_o2 == cipher_accept_o) &&
                   (cipher_data_o2 == cipher_data_o) && (cipher_key_o2 == cipher_key_o) &&
                   (data_o2 == data_o[63:32]);
            chk1("lockstep_mac32_instance", same, 1'b1);
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic put_block(input logic s, input logic l, input logic [63:0] k,
                             input logic [63:0] d);
        bit ok;
        ok = 0;
        start_i = s; last_i = l; key_i = k; data_i = d; valid_i = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            if (accept_o) ok = 1;
            @(negedge clk);
        end
        valid_i = 1'b0; start_i = 1'b0; last_i = 1'b0;
        chk1("input_block_accepted", ok, 1'b1);
    endtask

    task automatic wait_mac(input string tag, input logic [63:0] exp);
        logic [63:0] m;
        logic [31:0] m32;
        int          n;
        n = 0;
        while (mac_q.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk1({tag, "_mac_seen"}, mac_q.size() != 0, 1'b1);
        if (mac_q.size() != 0) begin
            m = mac_q.pop_front();
            m32 = mac32_q.pop_front();
            chk64({tag, "_mac"}, m, exp);
            chk64({tag, "_mac32"}, {32'h0, m32}, {32'h0, exp[63:32]});
        end
    endtask

    task automatic send_msg(input logic [63:0] k, input logic [63:0] b[4], input int n);
        for (int i = 0; i < n; i++) put_block(i == 0, i == n - 1, k, b[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_accept_o"}, accept_o, 1'b1);
        chk1({tag, "_valid_o"}, valid_o, 1'b0);
        chk1({tag, "_error_o"}, error_o, 1'b0);
        chk1({tag, "_cipher_valid_o"}, cipher_valid_o, 1'b0);
        chk1({tag, "_cipher_accept_o"}, cipher_accept_o, 1'b0);
        chk64({tag, "_data_o"}, data_o, 64'h0);
        chk64({tag, "_cipher_data_o"}, cipher_data_o, 64'h0);
        chk64({tag, "_cipher_key_o"}, cipher_key_o, 64'h0);
    endtask

    typedef struct {
        int          nblk;
        logic [63:0] key;
        logic [63:0] b0;
        logic [63:0] b1;
        logic [63:0] exp_mac;
        logic [63:0] exp_req_last;
    } vec_t;

    vec_t vecs[3];

    // ---------------- main sequence ----------------
    initial begin : main
        logic [63:0] blk[4];
        logic [63:0] k;
        int          e0, r0, n, nb;
        reset_i = 1'b1; start_i = 1'b0; last_i = 1'b0; valid_i = 1'b0;
        key_i = '0; data_i = '0;

        blk = '{64'h0F0F0F0F12345678, 64'hDEADBEEF00000001, 64'h0, 64'h0};
        vecs[0] = '{nblk: 1, key: KDES, b0: PDES, b1: 64'h0, exp_mac: CDES, exp_req_last: PDES};
        vecs[1] = '{nblk: 2, key: KDES, b0: PDES, b1: P2DES, exp_mac: CDES, exp_req_last: PDES};
        vecs[2] = '{nblk: 2, key: 64'h0F1E2D3C4B5A6978, b0: blk[0], b1: blk[1],
                    exp_mac: ref_mac(64'h0F1E2D3C4B5A6978, blk, 2),
                    exp_req_last: toy(64'h0F1E2D3C4B5A6978, blk[0]) ^ blk[1]};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_i = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            r0 = req_data_log.size();
            blk = '{vecs[v].b0, vecs[v].b1, 64'h0, 64'h0};
            send_msg(vecs[v].key, blk, vecs[v].nblk);
            wait_mac($sformatf("vec%0d", v), vecs[v].exp_mac);
            chk_int("vec_cipher_requests", req_data_log.size() - r0, vecs[v].nblk);
            chk64("vec_last_cipher_input", req_data_log[$], vecs[v].exp_req_last);
            chk64("vec_cipher_key", req_key_log[$], vecs[v].key);
            chk_int("vec_valid_rise_after_result", rise_cyc, res_cyc);
            repeat (6) @(negedge clk);
            chk_int("vec_single_mac_pulse", mac_q.size(), 0);
        end

        // Stray non-start block with no message open.
        e0 = err_cnt;
        r0 = req_data_log.size();
        put_block(1'b0, 1'b0, KDES, P2DES);
        repeat (4) @(negedge clk);
        chk_int("stray_error_cycles", err_cnt - e0, 1);
        chk_int("stray_no_cipher_request", req_data_log.size() - r0, 0);
        blk = '{PDES, 64'h0, 64'h0, 64'h0};
        send_msg(KDES, blk, 1);
        wait_mac("after_stray", CDES);

        // Cipher and sink back-pressure.
        cacc_hold = 5;
        sink_hold = 4;
        put_block(1'b1, 1'b1, KDES, PDES);
        for (int i = 0; i < 5; i++) begin
            chk1("bp_send_cipher_valid", cipher_valid_o, 1'b1);
            chk64("bp_send_cipher_data", cipher_data_o, PDES);
            chk1("bp_send_accept_o", accept_o, 1'b0);
            @(negedge clk);
        end
        n = 0;
        while (!valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            chk1("bp_out_valid_o", valid_o, 1'b1);
            chk64("bp_out_data_o", data_o, CDES);
            chk1("bp_out_accept_o", accept_o, 1'b0);
            @(negedge clk);
        end
        wait_mac("backpressure", CDES);

        // Reset while waiting for a cipher result.
        put_block(1'b1, 1'b0, KDES, PDES);
        n = 0;
        while (!cipher_accept_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk1("reached_wait_state", cipher_accept_o, 1'b1);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check_reset_outputs("midreset");
        mac_q.delete();
        mac32_q.delete();
        blk = '{PDES, 64'h0, 64'h0, 64'h0};
        send_msg(KDES, blk, 1);
        wait_mac("after_reset", CDES);

        // Randomized messages, some preceded by an abandoned partial message.
        e0 = err_cnt;
        for (int m = 0; m < 25; m++) begin
            if ($urandom_range(0, 3) == 0) begin
                k = {$urandom, $urandom};
                for (int i = 0; i < int'($urandom_range(1, 2)); i++)
                    put_block(i == 0, 1'b0, k, {$urandom, $urandom});
            end
            k = {$urandom, $urandom};
            nb = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) blk[i] = {$urandom, $urandom};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_msg(k, blk, nb);
            wait_mac($sformatf("rand%0d", m), ref_mac(k, blk, nb));
        end
        chk_int("random_no_errors", err_cnt - e0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
